ext_domain_pwr_seq: RTL and testbench



---
 rtl/ext_domain_pwr_seq.sv | 151 +++++++++++++++
 tb/tb_ext_domain_pwr_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_domain_pwr_seq.sv
// rtl/ext_domain_pwr_seq.sv - per-domain power sequencer for external subsystem domains
module ext_domain_pwr_seq #(
  parameter int N_DOMAINS   = 1,
  parameter int DLY_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_DOMAINS-1:0] pwr_req_i,
  input  logic [N_DOMAINS-1:0] switch_ack_i,
  input  logic [N_DOMAINS-1:0] intr_i,
  input  logic [N_DOMAINS-1:0] err_clr_i,
  output logic [N_DOMAINS-1:0] switch_o,
  output logic [N_DOMAINS-1:0] iso_o,
  output logic [N_DOMAINS-1:0] subsys_rst_no,
  output logic [N_DOMAINS-1:0] intr_o,
  output logic [N_DOMAINS-1:0] on_o,
  output logic [N_DOMAINS-1:0] done_o,
  output logic [N_DOMAINS-1:0] err_o,
  output logic                 busy_o
);

  // Counter must hold both the settle delay and the ack timeout.
  localparam int MAX_CNT = (DLY_CYCLES > ACK_TIMEOUT) ? DLY_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_UP_SW  = 3'd1,
    S_UP_RST = 3'd2,
    S_ON     = 3'd3,
    S_DN_ISO = 3'd4,
    S_DN_SW  = 3'd5
  } state_t;

  logic [N_DOMAINS-1:0] w_busy;
  logic [N_DOMAINS-1:0] w_on;

  genvar g;
  generate
    for (g = 0; g < N_DOMAINS; g++) begin : g_dom
      localparam logic [CW-1:0] DLY_LAST = CW'(DLY_CYCLES - 1);
      localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
      localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

      state_t        r_state;
      state_t        w_nxt;
      logic [CW-1:0] r_cnt;
      logic          r_err;
      logic          r_done;
      logic          r_sw;
      logic          r_iso;
      logic          r_rstn;
      logic          r_on;
      logic          w_set_err;
      logic          w_done;

      // Next-state rules; ack beats timeout, brown-out beats a request change.
      always_comb begin
        w_nxt     = r_state;
        w_set_err = 1'b0;
        w_done    = 1'b0;
        case (r_state)
          S_OFF: begin
            if (pwr_req_i[g]) w_nxt = S_UP_SW;
          end
          S_UP_SW: begin
            if (switch_ack_i[g]) begin
              w_nxt = S_UP_RST;
            end else if (r_cnt == ACK_LAST) begin
              w_nxt     = S_OFF;
              w_set_err = 1'b1;
            end
          end
          S_UP_RST: begin
            if (r_cnt == DLY_LAST) begin
              w_nxt  = S_ON;
              w_done = 1'b1;
            end
          end
          S_ON: begin
            if (!switch_ack_i[g]) begin
              w_nxt     = S_DN_SW;
              w_set_err = 1'b1;
            end else if (!pwr_req_i[g]) begin
              w_nxt = S_DN_ISO;
            end
          end
          S_DN_ISO: begin
            if (r_cnt == DLY_LAST) w_nxt = S_DN_SW;
          end
          S_DN_SW: begin
            if (!switch_ack_i[g]) begin
              w_nxt  = S_OFF;
              w_done = 1'b1;
            end else if (r_cnt == ACK_LAST) begin
              w_nxt     = S_OFF;
              w_set_err = 1'b1;
            end
          end
          default: w_nxt = S_OFF;
        endcase
      end

      // State, saturating dwell counter, sticky error and registered output decode.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_state <= S_OFF;
          r_cnt   <= '0;
          r_err   <= 1'b0;
          r_done  <= 1'b0;
          r_sw    <= 1'b0;
          r_iso   <= 1'b1;
          r_rstn  <= 1'b0;
          r_on    <= 1'b0;
        end else begin
          r_state <= w_nxt;
          if (w_nxt != r_state) begin
            r_cnt <= '0;
          end else if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (w_set_err) begin
            r_err <= 1'b1;
          end else if (err_clr_i[g]) begin
            r_err <= 1'b0;
          end
          r_done <= w_done;
          r_sw   <= (w_nxt == S_UP_SW) || (w_nxt == S_UP_RST) ||
                    (w_nxt == S_ON)    || (w_nxt == S_DN_ISO);
          r_iso  <= (w_nxt != S_ON);
          r_rstn <= (w_nxt == S_UP_RST) || (w_nxt == S_ON) || (w_nxt == S_DN_ISO);
          r_on   <= (w_nxt == S_ON);
        end
      end

      assign switch_o[g]      = r_sw;
      assign iso_o[g]         = r_iso;
      assign subsys_rst_no[g] = r_rstn;
      assign done_o[g]        = r_done;
      assign err_o[g]         = r_err;
      assign w_on[g]          = r_on;
      assign w_busy[g]        = (r_state != S_ON) && (r_state != S_OFF);
    end
  endgenerate

  assign on_o   = w_on;
  assign intr_o = intr_i & w_on;
  assign busy_o = |w_busy;

endmodule

// File: tb/tb_ext_domain_pwr_seq.sv
// tb/tb_ext_domain_pwr_seq.sv - self-checking bench for ext_domain_pwr_seq
module tb_ext_domain_pwr_seq;

  localparam int ND  = 2;
  localparam int DLY = 4;
  localparam int TO  = 16;

  localparam int P_OFF = 0, P_UPSW = 1, P_UPRST = 2, P_ON = 3, P_DNISO = 4, P_DNSW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [ND-1:0] pwr_req_i = '0;
  logic [ND-1:0] switch_ack_i = '0;
  logic [ND-1:0] intr_i = '0;
  logic [ND-1:0] err_clr_i = '0;
  logic [ND-1:0] switch_o, iso_o, subsys_rst_no, intr_o, on_o, done_o, err_o;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  ext_domain_pwr_seq #(.N_DOMAINS(ND), .DLY_CYCLES(DLY), .ACK_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pwr_req_i(pwr_req_i), .switch_ack_i(switch_ack_i),
    .intr_i(intr_i), .err_clr_i(err_clr_i), .switch_o(switch_o), .iso_o(iso_o),
    .subsys_rst_no(subsys_rst_no), .intr_o(intr_o), .on_o(on_o), .done_o(done_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Output pattern per phase, bit index = phase number.
  bit [5:0] sw_tab   = 6'b011110;
  bit [5:0] iso_tab  = 6'b110111;
  bit [5:0] rstn_tab = 6'b011100;

  // Reference model: phase plus cycles already spent in it.
  int m_ph[ND]   = '{default: 0};
  int m_age[ND]  = '{default: 0};
  bit m_err[ND]  = '{default: 0};
  bit m_done[ND] = '{default: 0};
  int n_ph[ND];
  int n_age[ND];
  bit n_err[ND];
  bit n_done[ND];
  bit n_set[ND];

  always_comb begin
    for (int d = 0; d < ND; d++) begin
      n_ph[d]   = m_ph[d];
      n_done[d] = 1'b0;
      n_set[d]  = 1'b0;
      case (m_ph[d])
        P_OFF:   if (pwr_req_i[d]) n_ph[d] = P_UPSW;
        P_UPSW:  if (switch_ack_i[d]) n_ph[d] = P_UPRST;
                 else if (m_age[d] + 1 >= TO) begin n_ph[d] = P_OFF; n_set[d] = 1'b1; end
        P_UPRST: if (m_age[d] + 1 >= DLY) begin n_ph[d] = P_ON; n_done[d] = 1'b1; end
        P_ON:    if (!switch_ack_i[d]) begin n_ph[d] = P_DNSW; n_set[d] = 1'b1; end
                 else if (!pwr_req_i[d]) n_ph[d] = P_DNISO;
        P_DNISO: if (m_age[d] + 1 >= DLY) n_ph[d] = P_DNSW;
        P_DNSW:  if (!switch_ack_i[d]) begin n_ph[d] = P_OFF; n_done[d] = 1'b1; end
                 else if (m_age[d] + 1 >= TO) begin n_ph[d] = P_OFF; n_set[d] = 1'b1; end
        default: n_ph[d] = P_OFF;
      endcase
      n_age[d] = (n_ph[d] == m_ph[d]) ? m_age[d] + 1 : 0;
      n_err[d] = n_set[d] | (m_err[d] & ~err_clr_i[d]);
    end
  end

  always @(posedge clk_i or posedge rst_i) begin
    for (int d = 0; d < ND; d++) begin
      if (rst_i) begin
        m_ph[d] <= P_OFF; m_age[d] <= 0; m_err[d] <= 1'b0; m_done[d] <= 1'b0;
      end else begin
        m_ph[d] <= n_ph[d]; m_age[d] <= n_age[d]; m_err[d] <= n_err[d]; m_done[d] <= n_done[d];
      end
    end
  end

  function automatic logic [ND-1:0] exp_vec(input int kind);
    logic [ND-1:0] v;
    for (int d = 0; d < ND; d++) begin
      case (kind)
        0: v[d] = sw_tab[m_ph[d]];
        1: v[d] = iso_tab[m_ph[d]];
        2: v[d] = rstn_tab[m_ph[d]];
        3: v[d] = (m_ph[d] == P_ON);
        4: v[d] = m_done[d];
        5: v[d] = m_err[d];
        6: v[d] = intr_i[d] & (m_ph[d] == P_ON);
        default: v[d] = (m_ph[d] != P_ON) && (m_ph[d] != P_OFF);
      endcase
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every cycle, away from the active edge, compare all outputs against the model.
  always @(negedge clk_i) begin
    chk("cmp_switch", 32'(switch_o),      32'(exp_vec(0)));
    chk("cmp_iso",    32'(iso_o),         32'(exp_vec(1)));
    chk("cmp_rstn",   32'(subsys_rst_no), 32'(exp_vec(2)));
    chk("cmp_on",     32'(on_o),          32'(exp_vec(3)));
    chk("cmp_done",   32'(done_o),        32'(exp_vec(4)));
    chk("cmp_err",    32'(err_o),         32'(exp_vec(5)));
    chk("cmp_intr",   32'(intr_o),        32'(exp_vec(6)));
    chk("cmp_busy",   32'(busy_o),        32'(|exp_vec(7)));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_switch", 32'(switch_o), 32'h0);
    chk("rst_iso", 32'(iso_o), 32'h3);
    chk("rst_rstn", 32'(subsys_rst_no), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    rst_i = 1'b0;
    step(1);

    // Power-up: ack returned 3 cycles after switch rises
    pwr_req_i[0] = 1'b1;
    step(1);
    chk("up_sw_on", 32'(switch_o[0]), 32'h1);
    chk("up_busy", 32'(busy_o), 32'h1);
    step(3);
    switch_ack_i[0] = 1'b1;
    step(1);
    chk("up_rst_rel", 32'(subsys_rst_no[0]), 32'h1);
    chk("up_iso_hold", 32'(iso_o[0]), 32'h1);
    step(3);
    chk("up_iso_still", 32'(iso_o[0]), 32'h1);
    chk("up_nodone", 32'(done_o[0]), 32'h0);
    step(1);
    chk("up_iso_rel", 32'(iso_o[0]), 32'h0);
    chk("up_done", 32'(done_o[0]), 32'h1);
    chk("dom1_quiet", 32'({switch_o[1], iso_o[1], subsys_rst_no[1]}), 32'h2);
    intr_i = 2'b11;
    #1;
    chk("up_intr", 32'(intr_o), 32'h1);
    step(1);
    chk("up_done_pulse", 32'(done_o[0]), 32'h0);

    // Power-down: ack falls 2 cycles after switch falls
    pwr_req_i[0] = 1'b0;
    step(1);
    chk("dn_iso", 32'(iso_o[0]), 32'h1);
    chk("dn_intr_gate", 32'(intr_o[0]), 32'h0);
    step(3);
    chk("dn_sw_held", 32'({switch_o[0], subsys_rst_no[0]}), 32'h3);
    step(1);
    chk("dn_sw_open", 32'({switch_o[0], subsys_rst_no[0]}), 32'h0);
    step(2);
    switch_ack_i[0] = 1'b0;
    step(1);
    chk("dn_done", 32'(done_o[0]), 32'h1);
    chk("dn_err", 32'(err_o[0]), 32'h0);
    chk("dn_busy", 32'(busy_o), 32'h0);

    // Up timeout, clear, and set beating a simultaneous clear
    pwr_req_i[0] = 1'b1;
    step(1);
    step(15);
    chk("to_still_up", 32'(switch_o[0]), 32'h1);
    step(1);
    chk("to_sw", 32'(switch_o[0]), 32'h0);
    chk("to_err", 32'(err_o[0]), 32'h1);
    chk("to_nodone", 32'(done_o[0]), 32'h0);
    pwr_req_i[0] = 1'b0;
    err_clr_i[0] = 1'b1;
    step(1);
    err_clr_i[0] = 1'b0;
    chk("to_clr", 32'(err_o[0]), 32'h0);
    pwr_req_i[0] = 1'b1;
    step(16);
    err_clr_i[0] = 1'b1;
    step(1);
    err_clr_i[0] = 1'b0;
    pwr_req_i[0] = 1'b0;
    chk("to_set_wins", 32'(err_o[0]), 32'h1);
    err_clr_i[0] = 1'b1;
    step(1);
    err_clr_i[0] = 1'b0;
    chk("to_clr2", 32'(err_o[0]), 32'h0);

    // Brown-out while ON
    pwr_req_i[0] = 1'b1;
    switch_ack_i[0] = 1'b1;
    step(6);
    chk("bo_on", 32'(on_o[0]), 32'h1);
    chk("bo_intr_on", 32'(intr_o[0]), 32'h1);
    switch_ack_i[0] = 1'b0;
    pwr_req_i[0] = 1'b0;
    step(1);
    chk("bo_outs", 32'({switch_o[0], iso_o[0], subsys_rst_no[0]}), 32'h2);
    chk("bo_err", 32'(err_o[0]), 32'h1);
    chk("bo_intr_gate", 32'(intr_o[0]), 32'h0);
    step(1);
    err_clr_i[0] = 1'b1;
    step(1);
    err_clr_i[0] = 1'b0;

    // Request reversal during UP_RST
    pwr_req_i[0] = 1'b1;
    switch_ack_i[0] = 1'b1;
    step(2);
    pwr_req_i[0] = 1'b0;
    step(3);
    chk("rev_not_on", 32'(on_o[0]), 32'h0);
    step(1);
    chk("rev_done", 32'(done_o[0]), 32'h1);
    step(1);
    chk("rev_dniso", 32'({on_o[0], iso_o[0], switch_o[0]}), 32'h3);
    step(4);
    switch_ack_i[0] = 1'b0;
    step(1);
    chk("rev_off", 32'(done_o[0]), 32'h1);

    // Mid-sequence reset while domain 0 is in DN_ISO and domain 1 has an error
    pwr_req_i = 2'b11;
    switch_ack_i = 2'b11;
    step(6);
    chk("mr_both_on", 32'(on_o), 32'h3);
    pwr_req_i[0] = 1'b0;
    switch_ack_i[1] = 1'b0;
    step(1);
    chk("mr_err1", 32'(err_o[1]), 32'h1);
    step(1);
    #1 rst_i = 1'b1;
    #1;
    chk("mr_outs", 32'({switch_o, iso_o, subsys_rst_no}), 32'h0c);
    chk("mr_err", 32'(err_o), 32'h0);
    chk("mr_misc", 32'({on_o, done_o, intr_o, 1'b0, busy_o}), 32'h0);
    step(1);
    rst_i = 1'b0;
    pwr_req_i[0] = 1'b1;
    switch_ack_i[0] = 1'b1;
    step(1);
    chk("mr_up_sw", 32'(switch_o[0]), 32'h1);
    step(4);
    chk("mr_up_iso", 32'(iso_o[0]), 32'h1);
    step(1);
    chk("mr_up_done", 32'({on_o[0], done_o[0]}), 32'h3);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
